// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: headings (also used by the button block),
// game states and default playfield dimensions.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    localparam int DEF_GRID_W = 32;
    localparam int DEF_GRID_H = 24;

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Control/status bundle between the game sequencer and its surroundings
// (button block, body logic, renderer). The slave modport is the controller side.
interface snake_move_ctrl_if #(
    parameter int GRID_W  = snake_pkg::DEF_GRID_W,
    parameter int GRID_H  = snake_pkg::DEF_GRID_H,
    parameter int MAX_LEN = 64
) ();
    import snake_pkg::*;

    logic                         start;
    dir_e                         direction;
    logic                         grow;
    logic                         self_hit;
    state_e                       state;
    logic                         step;
    logic [$clog2(GRID_W)-1:0]    head_x;
    logic [$clog2(GRID_H)-1:0]    head_y;
    logic [$clog2(MAX_LEN+1)-1:0] length;
    logic                         game_over;

    modport master (
        output start, direction, grow, self_hit,
        input  state, step, head_x, head_y, length, game_over
    );

    modport slave (
        input  start, direction, grow, self_hit,
        output state, step, head_x, head_y, length, game_over
    );

endinterface

// File: rtl/snake_tick_gen.sv
// Movement-step divider: counts 0..DIV-1 while enabled and flags the terminal
// count combinationally so the caller can register its reaction on the wrap edge.
module snake_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);
    localparam int              CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tc   = i_en && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake head sequencer: IDLE/RUN/OVER game FSM, periodic head movement with wall
// and self-collision detection, and a saturating length counter fed by grow pulses.
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 5000000,
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int START_X  = 16,
    parameter int START_Y  = 12,
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 64
) (
    input logic              clk,
    input logic              reset,
    snake_move_ctrl_if.slave bus
);
    localparam int X_W = $clog2(GRID_W);
    localparam int Y_W = $clog2(GRID_H);
    localparam int L_W = $clog2(MAX_LEN + 1);

    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
    localparam logic [X_W-1:0] X_LAST  = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(GRID_H - 1);
    localparam logic [L_W-1:0] L_INIT  = L_W'(INIT_LEN);
    localparam logic [L_W-1:0] L_MAX   = L_W'(MAX_LEN);

    state_e         r_state, w_state_nxt;
    logic [X_W-1:0] r_head_x, w_head_x_nxt, w_move_x;
    logic [Y_W-1:0] r_head_y, w_head_y_nxt, w_move_y;
    logic [L_W-1:0] r_length, w_length_nxt, w_len_inc;
    logic           r_grow_pend, w_grow_pend_nxt;
    logic           r_step, w_step_nxt;
    logic           r_game_over;
    logic           w_tick, w_wall, w_div_en, w_div_clr;

    // Divider only runs while staying in RUN, so it reads 0 on every RUN entry.
    assign w_div_en  = (r_state == ST_RUN);
    assign w_div_clr = (w_state_nxt != ST_RUN);

    snake_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (reset),
        .i_en  (w_div_en),
        .i_clr (w_div_clr),
        .o_tc  (w_tick)
    );

    assign w_len_inc = (r_length < L_MAX) ? r_length + 1'b1 : r_length;

    // Candidate head; the underflow cases are caught explicitly before the wrap matters.
    always_comb begin
        w_move_x = r_head_x;
        w_move_y = r_head_y;
        w_wall   = 1'b0;
        case (bus.direction)
            DIR_UP: begin
                w_wall   = (r_head_y == '0);
                w_move_y = r_head_y - 1'b1;
            end
            DIR_DOWN: begin
                w_wall   = (r_head_y == Y_LAST);
                w_move_y = r_head_y + 1'b1;
            end
            DIR_LEFT: begin
                w_wall   = (r_head_x == '0);
                w_move_x = r_head_x - 1'b1;
            end
            default: begin
                w_wall   = (r_head_x == X_LAST);
                w_move_x = r_head_x + 1'b1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_head_x_nxt    = r_head_x;
        w_head_y_nxt    = r_head_y;
        w_length_nxt    = r_length;
        w_grow_pend_nxt = r_grow_pend;
        w_step_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt     = ST_RUN;
                    w_head_x_nxt    = X_START;
                    w_head_y_nxt    = Y_START;
                    w_length_nxt    = L_INIT;
                    w_grow_pend_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus.grow) begin
                    w_grow_pend_nxt = 1'b1;
                end
                // A collision with the body takes priority over a coincident move.
                if (bus.self_hit) begin
                    w_state_nxt = ST_OVER;
                end else if (w_tick) begin
                    if (w_wall) begin
                        w_state_nxt = ST_OVER;
                    end else begin
                        w_head_x_nxt = w_move_x;
                        w_head_y_nxt = w_move_y;
                        w_step_nxt   = 1'b1;
                        if (r_grow_pend || bus.grow) begin
                            w_length_nxt    = w_len_inc;
                            w_grow_pend_nxt = 1'b0;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (bus.start) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_head_x    <= X_START;
            r_head_y    <= Y_START;
            r_length    <= L_INIT;
            r_grow_pend <= 1'b0;
            r_step      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_head_x    <= w_head_x_nxt;
            r_head_y    <= w_head_y_nxt;
            r_length    <= w_length_nxt;
            r_grow_pend <= w_grow_pend_nxt;
            r_step      <= w_step_nxt;
            r_game_over <= (w_state_nxt == ST_OVER);
        end
    end

    assign bus.state     = r_state;
    assign bus.step      = r_step;
    assign bus.head_x    = r_head_x;
    assign bus.head_y    = r_head_y;
    assign bus.length    = r_length;
    assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl: per-cycle vector table with expected outputs queued at
// drive time and compared after each edge, plus a hand sequence around async reset.
module tb_snake_move_ctrl;
    import snake_pkg::*;

    localparam int TICK = 4;
    localparam int GW   = 8;
    localparam int GH   = 8;
    localparam int ML   = 5;
    localparam int XW   = $clog2(GW);
    localparam int YW   = $clog2(GH);
    localparam int LW   = $clog2(ML + 1);

    typedef struct {
        int     idx;
        logic   start;
        dir_e   dir;
        logic   grow;
        logic   sh;
        state_e st;
        logic   step;
        int     x;
        int     y;
        int     len;
    } vec_t;

    logic   clk   = 1'b0;
    logic   reset = 1'b1;
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_main   = 0;
    vec_t   vecs[$];
    vec_t   exp_q[$];

    snake_move_ctrl_if #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML)) bus ();

    snake_move_ctrl #(
        .TICK_DIV (TICK),
        .GRID_W   (GW),
        .GRID_H   (GH),
        .START_X  (4),
        .START_Y  (4),
        .INIT_LEN (3),
        .MAX_LEN  (ML)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void add(logic s, dir_e d, logic g, logic h,
                                state_e st, logic stp, int x, int y, int len);
        vec_t v;
        v.idx = vecs.size(); v.start = s; v.dir = d; v.grow = g; v.sh = h;
        v.st = st; v.step = stp; v.x = x; v.y = y; v.len = len;
        vecs.push_back(v);
    endfunction

    function automatic void check_out(string name, state_e st, logic stp, int x, int y, int len);
        logic go;
        go = (st == ST_OVER);
        n_checks++;
        if (bus.state !== st || bus.step !== stp || bus.head_x !== XW'(x) ||
            bus.head_y !== YW'(y) || bus.length !== LW'(len) || bus.game_over !== go) begin
            n_errors++;
            $display("FAIL %s: got state=%0d step=%0b x=%0d y=%0d len=%0d over=%0b, want state=%0d step=%0b x=%0d y=%0d len=%0d over=%0b",
                     name, bus.state, bus.step, bus.head_x, bus.head_y, bus.length, bus.game_over,
                     st, stp, x, y, len, go);
        end
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        bus.start     = v.start;
        bus.direction = v.dir;
        bus.grow      = v.grow;
        bus.self_hit  = v.sh;
        exp_q.push_back(v);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                vec_t v;
                v = exp_q.pop_front();
                check_out($sformatf("vec%0d", v.idx), v.st, v.step, v.x, v.y, v.len);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.direction = DIR_RIGHT;
        bus.grow      = 1'b0;
        bus.self_hit  = 1'b0;

        // Run right to the east wall.
        add(1, DIR_RIGHT, 0, 0, ST_RUN, 0, 4, 4, 3);
        for (int k = 1; k <= 16; k++) begin
            if (k < 16) add(0, DIR_RIGHT, 0, 0, ST_RUN, (k % 4 == 0), 4 + k / 4, 4, 3);
            else        add(0, DIR_RIGHT, 0, 0, ST_OVER, 0, 7, 4, 3);
        end
        repeat (2) add(0, DIR_RIGHT, 1, 1, ST_OVER, 0, 7, 4, 3);
        // Restart through IDLE, then run up to the north wall.
        add(1, DIR_UP, 0, 0, ST_IDLE, 0, 7, 4, 3);
        add(1, DIR_UP, 0, 0, ST_RUN, 0, 4, 4, 3);
        for (int k = 1; k <= 20; k++) begin
            if (k < 20) add(0, DIR_UP, 0, 0, ST_RUN, (k % 4 == 0), 4, 4 - k / 4, 3);
            else        add(0, DIR_UP, 0, 0, ST_OVER, 0, 4, 0, 3);
        end
        // Grow: mid-interval, coincident with a step, then saturation; start in RUN ignored.
        add(1, DIR_LEFT, 0, 0, ST_IDLE, 0, 4, 0, 3);
        add(1, DIR_LEFT, 0, 0, ST_RUN, 0, 4, 4, 3);
        for (int k = 1; k <= 20; k++) begin
            logic g;
            int   len;
            g   = (k == 2 || k == 8 || k == 9 || k == 10 || k == 11);
            len = (k < 4) ? 3 : (k < 8) ? 4 : 5;
            if (k < 20) add((k == 5), DIR_LEFT, g, 0, ST_RUN, (k % 4 == 0), 4 - k / 4, 4, len);
            else        add(0, DIR_LEFT, 0, 0, ST_OVER, 0, 0, 4, 5);
        end
        // self_hit on a step cycle with a grow pending.
        add(1, DIR_RIGHT, 0, 0, ST_IDLE, 0, 0, 4, 5);
        add(1, DIR_RIGHT, 0, 0, ST_RUN, 0, 4, 4, 3);
        for (int k = 1; k <= 3; k++) add(0, DIR_RIGHT, (k == 3), 0, ST_RUN, 0, 4, 4, 3);
        add(0, DIR_RIGHT, 0, 1, ST_OVER, 0, 4, 4, 3);
        add(0, DIR_RIGHT, 0, 0, ST_OVER, 0, 4, 4, 3);
        // Back into RUN, one step taken before the async reset.
        add(1, DIR_RIGHT, 0, 0, ST_IDLE, 0, 4, 4, 3);
        add(1, DIR_RIGHT, 0, 0, ST_RUN, 0, 4, 4, 3);
        for (int k = 1; k <= 5; k++) add(0, DIR_RIGHT, 0, 0, ST_RUN, (k == 4), (k >= 4) ? 5 : 4, 4, 3);
        n_main = vecs.size();
        // After reset release: fresh start, first step after exactly TICK cycles.
        add(1, DIR_RIGHT, 0, 0, ST_RUN, 0, 4, 4, 3);
        for (int k = 1; k <= 4; k++) add(0, DIR_RIGHT, 0, 0, ST_RUN, (k == 4), (k == 4) ? 5 : 4, 4, 3);

        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", ST_IDLE, 0, 4, 4, 3);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < n_main; i++) drive(vecs[i]);

        repeat (2) @(posedge clk);
        #3;
        check_out("pre_reset", ST_RUN, 0, 5, 4, 3);
        reset = 1'b1;
        #1;
        check_out("async_reset", ST_IDLE, 0, 4, 4, 3);
        @(negedge clk);
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_out("start_in_reset", ST_IDLE, 0, 4, 4, 3);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_out("reset_release", ST_IDLE, 0, 4, 4, 3);

        for (int i = n_main; i < vecs.size(); i++) drive(vecs[i]);
        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/snake_move_ctrl.md
Name: snake_move_ctrl

Overview:
Game-sequencing controller for the snake head. It consumes the debounced, reversal-filtered direction from the button block and generates the periodic movement step. It advances the head coordinate, tracks snake length and detects wall/self collisions. It runs the IDLE/RUN/OVER game state machine that the VGA renderer and body-shift logic follow.

Parameters:
TICK_DIV, 5000000, clock cycles per movement step (>=2)
GRID_W, 32, playfield width in cells
GRID_H, 24, playfield height in cells
START_X, 16, head x after reset/restart
START_Y, 12, head y after reset/restart
INIT_LEN, 3, snake length after reset/restart
MAX_LEN, 64, length saturation value

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse from the start button
direction  input  2  current heading: UP=00, DOWN=01, LEFT=10, RIGHT=11
grow  input  1  one-cycle pulse, food eaten
self_hit  input  1  level, head overlaps body (from body logic)
state  output  2  IDLE=00, RUN=01, OVER=10
step  output  1  one-cycle pulse when the head moves
head_x  output  $clog2(GRID_W)  head column
head_y  output  $clog2(GRID_H)  head row
length  output  $clog2(MAX_LEN+1)  current snake length
game_over  output  1  high while state==OVER

Behaviour:
- Reset (async, active-high) values: state=IDLE, step=0, head=(START_X,START_Y), length=INIT_LEN, game_over=0, divider=0, grow_pend=0.
- IDLE: divider is held at 0. On a start pulse, go to RUN next cycle and reload head/length/grow_pend to their initial values.
- RUN:
  - The divider counts 0..TICK_DIV-1 and wraps. The step event fires in the cycle after the divider reaches TICK_DIV-1, so the first step arrives TICK_DIV cycles after entering RUN.
  - On each step event, direction is sampled in that cycle. The next head is computed: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1.
  - Wall check uses unsigned compare plus explicit underflow test: x==0&&LEFT, y==0&&UP, x==GRID_W-1&&RIGHT, y==GRID_H-1&&DOWN.
  - If the move is legal: head updates and step=1 for exactly one cycle, registered with the head update.
  - If it is a wall move: head holds, step stays 0, state becomes OVER.
- grow:
  - A grow pulse in RUN sets the sticky grow_pend.
  - On the next legal step, length increments (saturating at MAX_LEN) and grow_pend clears.
  - A grow arriving in the same cycle as a step applies on that step.
- self_hit:
  - self_hit sampled high in RUN forces OVER next cycle.
  - If it coincides with a step event, self_hit wins: no move, no step pulse, no length change.
- OVER: game_over=1. Head and length are frozen, divider is held at 0, grow and self_hit are ignored. A start pulse returns to IDLE; a second start then enters RUN.
- start while in RUN is ignored.
- Reset mid-game returns everything to reset values immediately, regardless of state or divider value.
- Outputs are fully registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package snake_pkg holds:
  - direction encodings DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT, shared with the button block;
  - state encodings ST_IDLE/ST_RUN/ST_OVER;
  - default GRID_W/GRID_H.
- One sub-module, snake_tick_gen: parameterised divider with enable and synchronous clear, outputs a terminal-count pulse.
- The FSM, head arithmetic and length counter stay in snake_move_ctrl.

Test Plan:
Bench parameters: TICK_DIV=4, GRID 8x8, START (4,4), INIT_LEN=3, MAX_LEN=5.
1. Reset then start pulse with direction=RIGHT -> state=01; step pulses every 4 cycles; head_x goes 5,6,7; the next step hits the wall -> state=10, game_over=1, head stays (7,4), no fourth step pulse.
2. RUN with direction=UP from (4,4) -> head_y goes 3,2,1,0; the next step -> OVER with head (4,0), which checks y underflow.
3. Grow pulse mid-interval, then a grow coincident with a step, then 3 more grows -> length goes 3,4,5 then saturates at 5.
4. self_hit asserted in the same cycle as a step event -> no step pulse; head unchanged; state=OVER next cycle.
5. In OVER, pulse start -> IDLE; pulse start again -> RUN with head (4,4), length 3, first step exactly 4 cycles later.
6. Assert reset asynchronously mid-interval during RUN (between clock edges) -> outputs return to reset values immediately; start is ignored while reset is held.
